// File: rtl/lc3_mem_initiator.sv
// lc3_mem_initiator: single-outstanding bus initiator for the LC-3 SRAM/ROM port.
// Wait-stated access sequencing, registered read data, valid/ready response.
module lc3_mem_initiator #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_address,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [15:0] sram_address,
  output logic [15:0] sram_write_data,
  output logic        sram_write_enable,
  output logic        sram_output_enable,
  input  logic [15:0] sram_read_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state;
  state_t      state_next;
  logic [3:0]  count;
  logic [3:0]  count_next;
  logic [15:0] addr_q;
  logic [15:0] addr_next;
  logic [15:0] data_q;
  logic [15:0] data_next;
  logic        write_q;
  logic        write_next;
  logic [15:0] rsp_q;
  logic [15:0] rsp_next;

  assign rsp_data = rsp_q;

  // State, latched request and captured read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= 4'd0;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      write_q <= 1'b0;
      rsp_q   <= 16'h0000;
    end else begin
      state   <= state_next;
      count   <= count_next;
      addr_q  <= addr_next;
      data_q  <= data_next;
      write_q <= write_next;
      rsp_q   <= rsp_next;
    end
  end

  // Next state and bus/handshake decode from registered state.
  always_comb begin
    state_next         = state;
    count_next         = count;
    addr_next          = addr_q;
    data_next          = data_q;
    write_next         = write_q;
    rsp_next           = rsp_q;
    req_ready          = 1'b0;
    rsp_valid          = 1'b0;
    busy               = 1'b0;
    sram_address       = 16'h0000;
    sram_write_data    = 16'h0000;
    sram_write_enable  = 1'b0;
    sram_output_enable = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
      end
      ACCESS: begin
        busy               = 1'b1;
        sram_address       = addr_q;
        sram_write_data    = data_q;
        sram_write_enable  = write_q;
        sram_output_enable = !write_q;
        if (count != 4'd0) begin
          count_next = count - 4'd1;
        end else begin
          rsp_next   = sram_read_data;
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Load data is kept at zero so the write-data bus stays quiet on reads.
    if (req_valid && req_ready) begin
      state_next = ACCESS;
      count_next = WAIT_INIT;
      addr_next  = req_address;
      data_next  = req_write ? req_data : 16'h0000;
      write_next = req_write;
    end
  end

endmodule

// File: tb/tb_lc3_mem_initiator.sv
// tb_lc3_mem_initiator: three initiators (0, 2 and 3 wait states) on bench SRAMs.
// Directed scenarios plus random traffic against a transaction-level model.
module tb_lc3_mem_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0]       req_write;
  logic [2:0]       rsp_valid;
  logic [2:0]       rsp_ready;
  logic [2:0]       sram_write_enable;
  logic [2:0]       sram_output_enable;
  logic [2:0]       busy;
  logic [2:0][15:0] req_address;
  logic [2:0][15:0] req_data;
  logic [2:0][15:0] rsp_data;
  logic [2:0][15:0] sram_address;
  logic [2:0][15:0] sram_write_data;
  logic [2:0][15:0] sram_read_data;

  logic [15:0] mem [3][65536];

  int passed = 0;
  int total = 0;

  localparam logic [15:0] PROG [7] = '{16'h9040, 16'h5060, 16'h9000,
    16'h103F, 16'h0BFE, 16'hF025, 16'h0FF9};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lc3_mem_initiator #(
      .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) u_dut (
      .clk(clk),
      .reset_n(reset_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_write(req_write[g]),
      .req_address(req_address[g]),
      .req_data(req_data[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_data(rsp_data[g]),
      .sram_address(sram_address[g]),
      .sram_write_data(sram_write_data[g]),
      .sram_write_enable(sram_write_enable[g]),
      .sram_output_enable(sram_output_enable[g]),
      .sram_read_data(sram_read_data[g]),
      .busy(busy[g])
    );
    // Write-through SRAM: a store reads back the data being written.
    assign sram_read_data[g] = sram_write_enable[g] ? sram_write_data[g]
                                                    : mem[g][sram_address[g]];
  end

  // Bench SRAM write port.
  always @(posedge clk)
    for (int g = 0; g < 3; g++)
      if (sram_write_enable[g] === 1'b1)
        mem[g][sram_address[g]] = sram_write_data[g];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int wait_of(input int k);
    return k == 0 ? 0 : (k == 1 ? 2 : 3);
  endfunction

  function automatic logic [15:0] init_val(input int a);
    if (a >= 'h3000 && a <= 'h3006) return PROG[a - 'h3000];
    return 16'(a) ^ 16'hA5A5;
  endfunction

  task automatic init_mem();
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 65536; a++)
        mem[k][a] = init_val(a);
  endtask

  task automatic idle_inputs();
    req_valid   = '0;
    req_write   = '0;
    rsp_ready   = '0;
    req_address = '0;
    req_data    = '0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One request with rsp_ready held high; observes bus cycles and latency.
  task automatic run_one(input int k, input bit w, input logic [15:0] a,
                         input logic [15:0] d, output int en, output int lat,
                         output logic [15:0] rd, output bit bad);
    en  = 0;
    lat = 0;
    rd  = 'x;
    bad = 0;
    @(negedge clk);
    req_valid[k]   = 1'b1;
    req_write[k]   = w;
    req_address[k] = a;
    req_data[k]    = d;
    rsp_ready[k]   = 1'b1;
    @(negedge clk);
    req_valid[k] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      lat++;
      if (rsp_valid[k] === 1'b1) begin
        rd = rsp_data[k];
        break;
      end
      if (sram_write_enable[k] !== 1'b0 || sram_output_enable[k] !== 1'b0) begin
        en++;
        if (sram_address[k] !== a || sram_write_enable[k] !== w ||
            sram_output_enable[k] !== !w ||
            sram_write_data[k] !== (w ? d : 16'h0000))
          bad = 1;
      end
      @(negedge clk);
    end
    @(negedge clk);
    rsp_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if ({req_ready[k], rsp_valid[k], sram_write_enable[k],
             sram_output_enable[k], busy[k], sram_address[k],
             sram_write_data[k], rsp_data[k]} !== {5'b10000, 48'h0})
          $display("FAIL reset_idle k=%0d c=%0d got %b_%h_%h_%h want 10000_0000_0000_0000",
                   k, c, {req_ready[k], rsp_valid[k], sram_write_enable[k],
                   sram_output_enable[k], busy[k]}, sram_address[k],
                   sram_write_data[k], rsp_data[k]);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_read_w0();
    int en, lat;
    logic [15:0] rd;
    bit bad;
    run_one(0, 1'b0, 16'h3000, 16'h0000, en, lat, rd, bad);
    total++;
    if (en !== 1) $display("FAIL read_w0_oe_cycles got %0d want 1", en);
    else passed++;
    total++;
    if (lat !== 2) $display("FAIL read_w0_latency got %0d want 2", lat);
    else passed++;
    total++;
    if (rd !== 16'h9040) $display("FAIL read_w0_data got %h want 9040", rd);
    else passed++;
    total++;
    if (bad !== 1'b0) $display("FAIL read_w0_bus got %0d want 0", bad);
    else passed++;
  endtask

  task automatic test_store_w2();
    int en, lat;
    logic [15:0] rd;
    bit bad;
    run_one(1, 1'b1, 16'h4000, 16'h1234, en, lat, rd, bad);
    total++;
    if (en !== 3) $display("FAIL store_w2_we_cycles got %0d want 3", en);
    else passed++;
    total++;
    if (lat !== 4) $display("FAIL store_w2_latency got %0d want 4", lat);
    else passed++;
    total++;
    if (rd !== 16'h1234) $display("FAIL store_w2_rsp got %h want 1234", rd);
    else passed++;
    total++;
    if (bad !== 1'b0) $display("FAIL store_w2_bus got %0d want 0", bad);
    else passed++;
    run_one(1, 1'b0, 16'h4000, 16'h0000, en, lat, rd, bad);
    total++;
    if (rd !== 16'h1234 || en !== 3 || bad !== 1'b0)
      $display("FAIL store_w2_readback got %h/%0d want 1234/3", rd, en);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] got[$];
    int rcyc[$];
    int issued = 0;
    int idle_seen = 0;
    bit fire;
    @(negedge clk);
    rsp_ready[0]   = 1'b1;
    req_valid[0]   = 1'b1;
    req_write[0]   = 1'b0;
    req_address[0] = 16'h3000;
    for (int c = 0; c < 40 && got.size() < 7; c++) begin
      #1 fire = req_valid[0] && req_ready[0];
      @(negedge clk);
      if (fire) begin
        issued++;
        if (issued < 7) req_address[0] = 16'h3000 + 16'(issued);
        else req_valid[0] = 1'b0;
      end
      if (issued > 0 && busy[0] !== 1'b1) idle_seen++;
      if (rsp_valid[0] === 1'b1) begin
        got.push_back(rsp_data[0]);
        rcyc.push_back(c);
      end
    end
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b0;
    total++;
    if (got.size() != 7) $display("FAIL b2b_count got %0d want 7", got.size());
    else passed++;
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== PROG[i])
        $display("FAIL b2b_data i=%0d got %h want %h", i, got[i], PROG[i]);
      else passed++;
      if (i > 0) begin
        total++;
        if (rcyc[i] - rcyc[i-1] != 2)
          $display("FAIL b2b_spacing i=%0d got %0d want 2", i, rcyc[i] - rcyc[i-1]);
        else passed++;
      end
    end
    total++;
    if (idle_seen != 0) $display("FAIL b2b_idle_bubble got %0d want 0", idle_seen);
    else passed++;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    rsp_ready[0]   = 1'b0;
    req_valid[0]   = 1'b1;
    req_write[0]   = 1'b0;
    req_address[0] = 16'h3001;
    @(negedge clk);
    req_address[0] = 16'h3002;
    for (int c = 0; c < 10 && rsp_valid[0] !== 1'b1; c++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if ({rsp_valid[0], req_ready[0], busy[0], rsp_data[0]} !== {3'b101, 16'h5060})
        $display("FAIL bp_hold c=%0d got %b_%h want 101_5060", c,
                 {rsp_valid[0], req_ready[0], busy[0]}, rsp_data[0]);
      else passed++;
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    #1;
    total++;
    if ({rsp_valid[0], req_ready[0]} !== 2'b11)
      $display("FAIL bp_release got %b want 11", {rsp_valid[0], req_ready[0]});
    else passed++;
    @(negedge clk);
    req_valid[0] = 1'b0;
    total++;
    if ({sram_output_enable[0], rsp_valid[0], sram_address[0]} !== {2'b10, 16'h3002})
      $display("FAIL bp_second_access got %b_%h want 10_3002",
               {sram_output_enable[0], rsp_valid[0]}, sram_address[0]);
    else passed++;
    @(negedge clk);
    total++;
    if ({rsp_valid[0], rsp_data[0]} !== {1'b1, 16'h9000})
      $display("FAIL bp_second_rsp got %b_%h want 1_9000", rsp_valid[0], rsp_data[0]);
    else passed++;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    total++;
    if ({busy[0], rsp_valid[0]} !== 2'b00)
      $display("FAIL bp_idle got %b want 00", {busy[0], rsp_valid[0]});
    else passed++;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int en, lat;
    logic [15:0] rd;
    bit bad;
    @(negedge clk);
    req_valid[2]   = 1'b1;
    req_write[2]   = 1'b1;
    req_address[2] = 16'h5000;
    req_data[2]    = 16'h5555;
    rsp_ready[2]   = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    total++;
    if ({sram_write_enable[2], sram_address[2]} !== {1'b1, 16'h5000})
      $display("FAIL mid_access2 got %b_%h want 1_5000", sram_write_enable[2], sram_address[2]);
    else passed++;
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({sram_write_enable[2], sram_output_enable[2], busy[2], rsp_valid[2],
         req_ready[2]} !== 5'b00001)
      $display("FAIL mid_after_reset got %b want 00001",
               {sram_write_enable[2], sram_output_enable[2], busy[2],
               rsp_valid[2], req_ready[2]});
    else passed++;
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid[2] !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL mid_no_rsp got %0d want 0", seen);
    else passed++;
    run_one(2, 1'b0, 16'h3000, 16'h0000, en, lat, rd, bad);
    total++;
    if ({rd, 8'(en), 8'(lat), 1'(bad)} !== {16'h9040, 8'd4, 8'd5, 1'b0})
      $display("FAIL mid_next_read got %h/%0d/%0d/%0d want 9040/4/5/0", rd, en, lat, bad);
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] ref_mem [int];
    int w, sent, done_n, cyc, acc_cyc;
    bit have, t_w, exp_rv, exp_act, fire, take, fire_prev;
    logic [15:0] t_a, t_d, t_exp, exp_a, exp_d;
    init_mem();
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      ref_mem.delete();
      w = wait_of(k);
      sent = 0; done_n = 0; cyc = 0; acc_cyc = 0;
      have = 0; t_w = 0; t_a = '0; t_d = '0; t_exp = '0; fire_prev = 0;
      while (done_n < 30 && cyc < 3000) begin
        exp_act = have && (cyc - acc_cyc) <= w + 1;
        exp_rv  = have && (cyc - acc_cyc) >= w + 2;
        exp_a   = exp_act ? t_a : 16'h0000;
        exp_d   = (exp_act && t_w) ? t_d : 16'h0000;
        total++;
        if ({rsp_valid[k], busy[k], sram_write_enable[k], sram_output_enable[k],
             sram_address[k], sram_write_data[k]} !==
            {exp_rv, have, exp_act && t_w, exp_act && !t_w, exp_a, exp_d})
          $display("FAIL rnd_bus k=%0d cyc=%0d got %b_%h_%h want %b_%h_%h", k, cyc,
                   {rsp_valid[k], busy[k], sram_write_enable[k], sram_output_enable[k]},
                   sram_address[k], sram_write_data[k],
                   {exp_rv, have, exp_act && t_w, exp_act && !t_w}, exp_a, exp_d);
        else passed++;
        if (exp_rv) begin
          total++;
          if (rsp_data[k] !== t_exp)
            $display("FAIL rnd_rsp k=%0d cyc=%0d got %h want %h", k, cyc, rsp_data[k], t_exp);
          else passed++;
        end
        if (fire_prev) req_valid[k] = 1'b0;
        rsp_ready[k] = ($urandom_range(0, 3) != 0);
        if (!req_valid[k] && sent < 30 && $urandom_range(0, 2) != 0) begin
          req_valid[k] = 1'b1;
          req_write[k] = 1'($urandom_range(0, 1));
          req_data[k]  = 16'($urandom);
          case ($urandom_range(0, 4))
            0: req_address[k] = 16'hFFFF;
            1: req_address[k] = 16'h0000;
            2: req_address[k] = 16'h3000 + 16'($urandom_range(0, 6));
            default: req_address[k] = 16'h4000 + 16'($urandom_range(0, 15));
          endcase
        end
        #1;
        take = exp_rv && rsp_ready[k];
        total++;
        if (req_ready[k] !== (!have || take))
          $display("FAIL rnd_req_ready k=%0d cyc=%0d got %b want %b", k, cyc,
                   req_ready[k], !have || take);
        else passed++;
        fire = req_valid[k] && (!have || take);
        if (take) begin
          have = 0;
          done_n++;
        end
        if (fire) begin
          have    = 1;
          t_w     = req_write[k];
          t_a     = req_address[k];
          t_d     = req_data[k];
          acc_cyc = cyc;
          sent++;
          if (t_w) begin
            t_exp = t_d;
            ref_mem[int'(t_a)] = t_d;
          end else begin
            t_exp = ref_mem.exists(int'(t_a)) ? ref_mem[int'(t_a)] : init_val(int'(t_a));
          end
        end
        fire_prev = fire;
        @(negedge clk);
        cyc++;
      end
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b0;
      total++;
      if (done_n != 30) $display("FAIL rnd_done k=%0d got %0d want 30", k, done_n);
      else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    init_mem();
    test_reset();
    test_read_w0();
    test_store_w2();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
